// File: rtl/pcie_cc_pkg.sv
// Shared constants, FSM state type and first_be helpers for the PCIe completer responder.
package pcie_cc_pkg;

  localparam logic [3:0] REQ_MEM_RD = 4'b0000;
  localparam logic [3:0] REQ_MEM_WR = 4'b0001;

  localparam logic [2:0] CPL_SC = 3'b000;
  localparam logic [2:0] CPL_UR = 3'b001;

  // Bit offsets of the CQ descriptor fields within beat1.
  localparam int DESC_DWCNT_LSB   = 0;
  localparam int DESC_REQTYPE_LSB = 11;
  localparam int DESC_REQID_LSB   = 16;
  localparam int DESC_TAG_LSB     = 32;
  localparam int DESC_BAR_LSB     = 48;
  localparam int DESC_TC_LSB      = 57;
  localparam int DESC_ATTR_LSB    = 60;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DESC1,
    ST_WDATA,
    ST_DRAIN,
    ST_CC0,
    ST_CC1
  } cc_state_e;

  function automatic logic [1:0] be_lower_bits(input logic [3:0] first_be);
    logic [1:0] lo;
    lo = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (first_be[i]) lo = 2'(i);
    end
    return lo;
  endfunction

  function automatic logic [12:0] be_byte_count(input logic [3:0] first_be);
    logic [1:0] hi;
    hi = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (first_be[i]) hi = 2'(i);
    end
    if (first_be == 4'b0000) return 13'd1;
    return 13'(hi - be_lower_bits(first_be)) + 13'd1;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/pcie_cc_responder_if.sv
// CQ and CC AXI-stream bundle between the PCIe core (master) and the responder (slave).
interface pcie_cc_responder_if #(
  parameter int CQ_TREADY_W = 22
);
  logic [63:0]            m_axis_cq_tdata;
  logic [84:0]            m_axis_cq_tuser;
  logic                   m_axis_cq_tlast;
  logic [1:0]             m_axis_cq_tkeep;
  logic                   m_axis_cq_tvalid;
  logic [CQ_TREADY_W-1:0] m_axis_cq_tready;

  logic [63:0]            s_axis_cc_tdata;
  logic [32:0]            s_axis_cc_tuser;
  logic                   s_axis_cc_tlast;
  logic [1:0]             s_axis_cc_tkeep;
  logic                   s_axis_cc_tvalid;
  logic [3:0]             s_axis_cc_tready;

  modport master (
    output m_axis_cq_tdata, m_axis_cq_tuser, m_axis_cq_tlast, m_axis_cq_tkeep, m_axis_cq_tvalid,
    input  m_axis_cq_tready,
    input  s_axis_cc_tdata, s_axis_cc_tuser, s_axis_cc_tlast, s_axis_cc_tkeep, s_axis_cc_tvalid,
    output s_axis_cc_tready
  );

  modport slave (
    input  m_axis_cq_tdata, m_axis_cq_tuser, m_axis_cq_tlast, m_axis_cq_tkeep, m_axis_cq_tvalid,
    output m_axis_cq_tready,
    output s_axis_cc_tdata, s_axis_cc_tuser, s_axis_cc_tlast, s_axis_cc_tkeep, s_axis_cc_tvalid,
    input  s_axis_cc_tready
  );
endinterface

// File: rtl/pcie_cc_regfile.sv
// BAR0 register file: byte-masked write port, registered read port, live tap of register 0.
module pcie_cc_regfile #(
  parameter  int REG_COUNT = 16,
  localparam int IDX_W     = $clog2(REG_COUNT)
) (
  input  logic             user_clk,
  input  logic             user_reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_be,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data,
  output logic [31:0]      dbg_reg0
);

  logic [31:0] regs [REG_COUNT];

  // NOTE: this small array is flops, not RAM, so it takes the reset and software sees zeros after reset.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_be[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
      if (rd_en) rd_data <= regs[rd_idx];
    end
  end

  assign dbg_reg0 = regs[0];

endmodule

// File: rtl/pcie_cc_responder.sv
// Completer responder: services 1-DW BAR0 MMIO reads/writes from CQ and answers reads on CC.
module pcie_cc_responder
  import pcie_cc_pkg::*;
#(
  parameter int REG_COUNT   = 16,
  parameter int CQ_TREADY_W = 22
) (
  input  logic               user_clk,
  input  logic               user_reset,
  pcie_cc_responder_if.slave pcie,
  output logic [15:0]        rd_count,
  output logic [15:0]        wr_count,
  output logic [15:0]        drop_count,
  output logic [31:0]        dbg_reg0
);

  localparam int IDX_W = $clog2(REG_COUNT);

  cc_state_e   state, state_nxt;
  logic        cq_ready, cq_fire, cc_valid, cc_fire;
  logic [63:0] cc_data;
  logic [1:0]  cc_keep;
  logic        cc_last;

  logic [4:0]  addr_lo;
  logic [3:0]  first_be;
  logic [15:0] req_id;
  logic [7:0]  tag;
  logic [2:0]  tc, attr, cpl_status;
  logic [31:0] rd_data;

  logic [63:0] cq_data;
  logic        cq_last;
  logic [10:0] d_dwcnt;
  logic [3:0]  d_type;
  logic [2:0]  d_bar;
  logic        desc_ok, desc_is_rd, desc_wr_ok;
  logic        rd_inc, wr_inc, drop_inc;

  assign cq_data    = pcie.m_axis_cq_tdata;
  assign cq_last    = pcie.m_axis_cq_tlast;
  assign d_dwcnt    = cq_data[DESC_DWCNT_LSB +: 11];
  assign d_type     = cq_data[DESC_REQTYPE_LSB +: 4];
  assign d_bar      = cq_data[DESC_BAR_LSB +: 3];
  assign desc_ok    = (d_bar == 3'd0) && (d_dwcnt == 11'd1);
  assign desc_is_rd = (d_type == REQ_MEM_RD);
  // A good write whose descriptor beat carries tlast has no payload to consume, so it is dropped.
  assign desc_wr_ok = (d_type == REQ_MEM_WR) && desc_ok && !cq_last;

  assign cq_fire = pcie.m_axis_cq_tvalid & cq_ready;
  assign cc_fire = cc_valid & pcie.s_axis_cc_tready[0];

  assign rd_inc   = (state == ST_CC1) && cc_fire && (cpl_status == CPL_SC);
  assign wr_inc   = (state == ST_WDATA) && cq_fire;
  assign drop_inc = cq_fire && (((state == ST_IDLE) && cq_last) ||
                                ((state == ST_DESC1) && !desc_is_rd && !desc_wr_ok));

  // NOTE: state and all other flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cq_fire) state_nxt = cq_last ? ST_IDLE : ST_DESC1;
      ST_DESC1: if (cq_fire) begin
        if (desc_is_rd)      state_nxt = ST_CC0;
        else if (desc_wr_ok) state_nxt = ST_WDATA;
        else                 state_nxt = cq_last ? ST_IDLE : ST_DRAIN;
      end
      ST_WDATA: if (cq_fire) state_nxt = cq_last ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: if (cq_fire && cq_last) state_nxt = ST_IDLE;
      ST_CC0:   if (cc_fire) state_nxt = ST_CC1;
      ST_CC1:   if (cc_fire) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves a latch behind.
  always_comb begin
    cq_ready = 1'b0;
    cc_valid = 1'b0;
    cc_data  = '0;
    cc_keep  = 2'b00;
    cc_last  = 1'b0;
    case (state)
      ST_IDLE, ST_DESC1, ST_WDATA, ST_DRAIN: cq_ready = 1'b1;
      ST_CC0: begin
        cc_valid = 1'b1;
        cc_keep  = 2'b11;
        cc_data  = {req_id, 2'b00, cpl_status,
                    (cpl_status == CPL_SC) ? 11'd1 : 11'd0,
                    3'b000, be_byte_count(first_be),
                    9'd0, addr_lo, be_lower_bits(first_be)};
      end
      ST_CC1: begin
        cc_valid = 1'b1;
        cc_last  = 1'b1;
        cc_keep  = (cpl_status == CPL_SC) ? 2'b11 : 2'b01;
        cc_data  = {(cpl_status == CPL_SC) ? rd_data : 32'h0,
                    1'b0, attr, tc, 1'b0, 16'h0000, tag};
      end
      default: ;
    endcase
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      addr_lo    <= '0;
      first_be   <= '0;
      req_id     <= '0;
      tag        <= '0;
      tc         <= '0;
      attr       <= '0;
      cpl_status <= CPL_SC;
      rd_count   <= '0;
      wr_count   <= '0;
      drop_count <= '0;
    end else begin
      if ((state == ST_IDLE) && cq_fire) begin
        addr_lo  <= cq_data[6:2];
        first_be <= pcie.m_axis_cq_tuser[3:0];
      end
      if ((state == ST_DESC1) && cq_fire) begin
        req_id     <= cq_data[DESC_REQID_LSB +: 16];
        tag        <= cq_data[DESC_TAG_LSB +: 8];
        tc         <= cq_data[DESC_TC_LSB +: 3];
        attr       <= cq_data[DESC_ATTR_LSB +: 3];
        cpl_status <= desc_ok ? CPL_SC : CPL_UR;
      end
      if (rd_inc)   rd_count   <= sat_inc(rd_count);
      if (wr_inc)   wr_count   <= sat_inc(wr_count);
      if (drop_inc) drop_count <= sat_inc(drop_count);
    end
  end

  // Read data is sampled on the DESC1 edge and then holds for the whole completion.
  pcie_cc_regfile #(.REG_COUNT(REG_COUNT)) u_regfile (
    .user_clk   (user_clk),
    .user_reset (user_reset),
    .wr_en      (wr_inc),
    .wr_idx     (addr_lo[IDX_W-1:0]),
    .wr_data    (cq_data[31:0]),
    .wr_be      (first_be),
    .rd_en      ((state == ST_DESC1) && cq_fire && desc_is_rd),
    .rd_idx     (addr_lo[IDX_W-1:0]),
    .rd_data    (rd_data),
    .dbg_reg0   (dbg_reg0)
  );

  assign pcie.m_axis_cq_tready = {CQ_TREADY_W{cq_ready}};
  assign pcie.s_axis_cc_tdata  = cc_data;
  assign pcie.s_axis_cc_tuser  = '0;
  assign pcie.s_axis_cc_tlast  = cc_last;
  assign pcie.s_axis_cc_tkeep  = cc_keep;
  assign pcie.s_axis_cc_tvalid = cc_valid;

  logic unused_ok;
  assign unused_ok = ^{pcie.m_axis_cq_tuser[84:4], pcie.m_axis_cq_tkeep, pcie.s_axis_cc_tready[3:1],
                       cq_data[63], cq_data[56:51], cq_data[47:40]};

endmodule

// File: tb/tb_pcie_cc_responder.sv
// Randomized self-checking bench for pcie_cc_responder against a transaction-level register model.
module tb_pcie_cc_responder;
  import pcie_cc_pkg::*;

  localparam int REG_COUNT     = 16;
  localparam int CQ_TREADY_W   = 22;
  localparam int BEAT_TIMEOUT  = 200;
  localparam logic [CQ_TREADY_W-1:0] TREADY_ALL = {CQ_TREADY_W{1'b1}};

  logic        user_clk = 1'b0;
  logic        user_reset = 1'b1;
  logic [15:0] rd_count, wr_count, drop_count;
  logic [31:0] dbg_reg0;

  pcie_cc_responder_if #(.CQ_TREADY_W(CQ_TREADY_W)) pcie ();

  pcie_cc_responder #(.REG_COUNT(REG_COUNT), .CQ_TREADY_W(CQ_TREADY_W)) dut (
    .user_clk   (user_clk),
    .user_reset (user_reset),
    .pcie       (pcie.slave),
    .rd_count   (rd_count),
    .wr_count   (wr_count),
    .drop_count (drop_count),
    .dbg_reg0   (dbg_reg0)
  );

  always #5 user_clk = ~user_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register contents and event counts.
  logic [31:0] m_reg [REG_COUNT];
  int m_rd, m_wr, m_drop;
  int bc_tab [16] = '{1, 1, 1, 2, 1, 3, 2, 3, 1, 4, 3, 4, 2, 4, 3, 4};
  int la_tab [16] = '{0, 0, 1, 0, 2, 0, 1, 0, 3, 0, 1, 0, 2, 0, 1, 0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int bump(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < REG_COUNT; i++) m_reg[i] = '0;
    m_rd = 0; m_wr = 0; m_drop = 0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_rd_count"},   rd_count,   64'(m_rd));
    check({tag, "_wr_count"},   wr_count,   64'(m_wr));
    check({tag, "_drop_count"}, drop_count, 64'(m_drop));
    check({tag, "_dbg_reg0"},   dbg_reg0,   m_reg[0]);
  endtask

  function automatic logic [63:0] desc1(input logic [3:0] rtype, input logic [10:0] dw,
                                        input logic [2:0] bar, input logic [15:0] reqid,
                                        input logic [7:0] tag, input logic [2:0] tc,
                                        input logic [2:0] attr);
    return {1'b0, attr, tc, 6'b0, bar, 8'h00, tag, reqid, 1'b0, rtype, dw};
  endfunction

  task automatic cq_beat(input logic [63:0] data, input logic [3:0] fbe, input logic last);
    int waited;
    logic [95:0] junk;
    waited = 0;
    junk = {$urandom, $urandom, $urandom};
    repeat ($urandom_range(0, 1)) @(negedge user_clk);
    @(negedge user_clk);
    pcie.m_axis_cq_tdata  = data;
    pcie.m_axis_cq_tuser  = {junk[80:0], fbe};
    pcie.m_axis_cq_tlast  = last;
    pcie.m_axis_cq_tkeep  = 2'b11;
    pcie.m_axis_cq_tvalid = 1'b1;
    while (pcie.m_axis_cq_tready !== TREADY_ALL && waited < BEAT_TIMEOUT) begin
      @(negedge user_clk);
      waited++;
    end
    check("cq_beat_accepted", 64'(waited < BEAT_TIMEOUT), 64'd1);
    if (waited < BEAT_TIMEOUT) @(posedge user_clk);
    #1;
    pcie.m_axis_cq_tvalid = 1'b0;
    pcie.m_axis_cq_tlast  = 1'b0;
  endtask

  // Entered #1 after the edge that accepted the descriptor beat of a read.
  task automatic expect_cc(input logic [63:0] e0, input logic [63:0] e1, input logic [1:0] k1,
                           input int bp0, input int bp1);
    logic [63:0] m1;
    m1 = k1[1] ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    check("cc_latency", pcie.s_axis_cc_tvalid, 1);
    for (int i = 0; i < bp0; i++) begin
      @(negedge user_clk);
      check("cc0_hold_valid", pcie.s_axis_cc_tvalid, 1);
      check("cc0_hold_data", pcie.s_axis_cc_tdata, e0);
      check("cc0_hold_cq_tready", pcie.m_axis_cq_tready, 0);
    end
    @(negedge user_clk);
    pcie.s_axis_cc_tready = {3'($urandom), 1'b1};
    check("cc0_data", pcie.s_axis_cc_tdata, e0);
    check("cc0_keep", pcie.s_axis_cc_tkeep, 2'b11);
    check("cc0_last", pcie.s_axis_cc_tlast, 0);
    @(posedge user_clk);
    #1;
    if (bp1 > 0) pcie.s_axis_cc_tready = {3'($urandom), 1'b0};
    @(negedge user_clk);
    check("cc1_valid", pcie.s_axis_cc_tvalid, 1);
    check("cc1_data", pcie.s_axis_cc_tdata & m1, e1 & m1);
    check("cc1_keep", pcie.s_axis_cc_tkeep, 64'(k1));
    check("cc1_last", pcie.s_axis_cc_tlast, 1);
    check("cc1_cq_tready", pcie.m_axis_cq_tready, 0);
    if (bp1 > 0) begin
      for (int i = 1; i < bp1; i++) begin
        @(negedge user_clk);
        check("cc1_hold_data", pcie.s_axis_cc_tdata & m1, e1 & m1);
        check("cc1_hold_cq_tready", pcie.m_axis_cq_tready, 0);
      end
      pcie.s_axis_cc_tready = {3'($urandom), 1'b1};
    end
    @(posedge user_clk);
    #1;
    pcie.s_axis_cc_tready = {3'($urandom), 1'b0};
    check("cc_done_valid", pcie.s_axis_cc_tvalid, 0);
    check("cc_done_cq_tready", pcie.m_axis_cq_tready, TREADY_ALL);
  endtask

  task automatic do_req(input logic [3:0] rtype, input logic [10:0] dw, input logic [2:0] bar,
                        input logic [63:0] addr, input logic [3:0] fbe, input logic [31:0] payload,
                        input logic [7:0] tag, input int n_beats, input int bp0, input int bp1);
    logic [15:0] reqid;
    logic [2:0]  tc, attr;
    logic [63:0] e0, e1;
    logic        sc;
    int          idx;
    reqid = 16'($urandom);
    tc    = 3'($urandom);
    attr  = 3'($urandom);
    idx   = int'(addr[63:2] % REG_COUNT);
    cq_beat({addr[63:2], 2'b00}, fbe, n_beats == 1);
    if (n_beats > 1) cq_beat(desc1(rtype, dw, bar, reqid, tag, tc, attr), fbe, n_beats == 2);
    for (int i = 2; i < n_beats; i++)
      cq_beat({$urandom, (i == 2) ? payload : $urandom}, fbe, i == n_beats - 1);

    if (n_beats == 1) begin
      check("malformed_no_cc", pcie.s_axis_cc_tvalid, 0);
      m_drop = bump(m_drop);
    end else if (rtype == REQ_MEM_RD) begin
      sc = (bar == 3'd0) && (dw == 11'd1);
      e0 = {reqid, 2'b00, sc ? 3'b000 : 3'b001, sc ? 11'd1 : 11'd0, 3'b000,
            13'(bc_tab[fbe]), 9'd0, addr[6:2], 2'(la_tab[fbe])};
      e1 = {sc ? m_reg[idx] : 32'h0, 1'b0, attr, tc, 1'b0, 16'h0000, tag};
      expect_cc(e0, e1, sc ? 2'b11 : 2'b01, bp0, bp1);
      if (sc) m_rd = bump(m_rd);
    end else begin
      check("nonread_no_cc", pcie.s_axis_cc_tvalid, 0);
      if (rtype == REQ_MEM_WR && bar == 3'd0 && dw == 11'd1 && n_beats >= 3) begin
        for (int b = 0; b < 4; b++)
          if (fbe[b]) m_reg[idx][8*b +: 8] = payload[8*b +: 8];
        m_wr = bump(m_wr);
      end else begin
        m_drop = bump(m_drop);
      end
    end
  endtask

  initial begin
    logic [3:0]  rtype;
    logic [2:0]  bar;
    logic [10:0] dw;
    logic [63:0] addr;
    int          kind;

    pcie.m_axis_cq_tdata  = '0;
    pcie.m_axis_cq_tuser  = '0;
    pcie.m_axis_cq_tlast  = 1'b0;
    pcie.m_axis_cq_tkeep  = 2'b00;
    pcie.m_axis_cq_tvalid = 1'b0;
    pcie.s_axis_cc_tready = 4'b0000;
    model_reset();

    repeat (3) @(negedge user_clk);
    check("reset_cc_tvalid", pcie.s_axis_cc_tvalid, 0);
    check("reset_cc_tdata",  pcie.s_axis_cc_tdata, 0);
    check("reset_cc_tkeep",  pcie.s_axis_cc_tkeep, 0);
    check("reset_cc_tlast",  pcie.s_axis_cc_tlast, 0);
    check("reset_cc_tuser",  pcie.s_axis_cc_tuser, 0);
    check("reset_cq_tready", pcie.m_axis_cq_tready, TREADY_ALL);
    check_counters("reset");
    user_reset = 1'b0;
    @(negedge user_clk);
    check("idle_cq_tready", pcie.m_axis_cq_tready, TREADY_ALL);

    // Write reg 3 then read it straight back.
    do_req(REQ_MEM_WR, 11'd1, 3'd0, 64'h0C, 4'hF, 32'hDEADBEEF, 8'h05, 3, 0, 0);
    do_req(REQ_MEM_RD, 11'd1, 3'd0, 64'h0C, 4'hF, 32'h0, 8'h06, 2, 0, 0);
    check("wr_then_rd_wr_count", wr_count, 1);
    check("wr_then_rd_rd_count", rd_count, 1);

    // Byte-masked write over a known value.
    do_req(REQ_MEM_WR, 11'd1, 3'd0, 64'h0, 4'hF, 32'hAAAAAAAA, 8'h07, 3, 0, 0);
    do_req(REQ_MEM_WR, 11'd1, 3'd0, 64'h0, 4'b0011, 32'h11223344, 8'h08, 3, 0, 0);
    check("byte_mask_dbg_reg0", dbg_reg0, 32'hAAAA3344);

    // Multi-DW read gets UR and does not count.
    do_req(REQ_MEM_RD, 11'd2, 3'd0, 64'h0C, 4'hF, 32'h0, 8'h09, 2, 0, 0);
    check("ur_rd_count", rd_count, 1);

    // Long CC backpressure on both beats.
    do_req(REQ_MEM_RD, 11'd1, 3'd0, 64'h0C, 4'b0110, 32'h0, 8'h0A, 2, 10, 3);

    // I/O write is swallowed whole.
    do_req(4'b0010, 11'd1, 3'd0, 64'h10, 4'hF, 32'h12345678, 8'h0B, 3, 0, 0);
    check("io_wr_drop_count", drop_count, 1);

    // Aliased address: upper bits ignored.
    do_req(REQ_MEM_WR, 11'd1, 3'd0, 64'hFFFF_0000_0000_1010, 4'hF, 32'hCAFEF00D, 8'h0C, 4, 0, 0);
    do_req(REQ_MEM_RD, 11'd1, 3'd0, 64'h10, 4'b1000, 32'h0, 8'h0D, 2, 1, 0);
    check_counters("directed");

    // Reset asserted while CC1 is presented.
    cq_beat(64'h14, 4'hF, 1'b0);
    cq_beat(desc1(REQ_MEM_RD, 11'd1, 3'd0, 16'h1234, 8'h44, 3'd0, 3'd0), 4'hF, 1'b1);
    check("rst_cc_latency", pcie.s_axis_cc_tvalid, 1);
    @(negedge user_clk);
    pcie.s_axis_cc_tready = 4'b0001;
    @(posedge user_clk);
    #1;
    pcie.s_axis_cc_tready = 4'b0000;
    check("rst_in_cc1_last", pcie.s_axis_cc_tlast, 1);
    @(negedge user_clk);
    user_reset = 1'b1;
    #1;
    check("rst_cc_tvalid", pcie.s_axis_cc_tvalid, 0);
    check("rst_cq_tready", pcie.m_axis_cq_tready, TREADY_ALL);
    model_reset();
    @(negedge user_clk);
    user_reset = 1'b0;
    check_counters("post_reset");
    do_req(REQ_MEM_RD, 11'd1, 3'd0, 64'h0C, 4'hF, 32'h0, 8'h0E, 2, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      addr = {$urandom, $urandom};
      bar  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      dw   = ($urandom_range(0, 5) == 0) ? 11'($urandom_range(2, 8)) : 11'd1;
      if (kind <= 3) begin
        do_req(REQ_MEM_RD, dw, bar, addr, 4'($urandom), 32'h0, 8'($urandom), 2,
               $urandom_range(0, 3), $urandom_range(0, 3));
      end else if (kind <= 6) begin
        do_req(REQ_MEM_WR, dw, bar, addr, 4'($urandom), $urandom, 8'($urandom),
               3 + $urandom_range(0, 1), 0, 0);
      end else if (kind == 7) begin
        rtype = 4'(2 + $urandom_range(0, 13));
        do_req(rtype, dw, bar, addr, 4'($urandom), $urandom, 8'($urandom),
               2 + $urandom_range(0, 1), 0, 0);
      end else if (kind == 8) begin
        do_req(4'($urandom), dw, bar, addr, 4'($urandom), 32'h0, 8'($urandom), 1, 0, 0);
      end else begin
        do_req(REQ_MEM_WR, 11'd1, 3'd0, addr, 4'($urandom), $urandom, 8'($urandom), 3, 0, 0);
        do_req(REQ_MEM_RD, 11'd1, 3'd0, addr, 4'hF, 32'h0, 8'($urandom), 2,
               $urandom_range(0, 2), $urandom_range(0, 2));
      end
      check_counters("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
